text_area_ctrl: RTL and testbench

- Host-side controller for the 8x8 text area.
- Owns the single port of the 84x64 cell RAM and shares it between the video scan reader (priority) and host commands (cell write, rectangle fill).
- Holds the scroll-offset and text-area-alpha configuration registers that the text area datapath consumes.
- Sits between the CPU bus bridge and the text area pixel pipeline.

---
 rtl/text_area_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_text_area_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_area_ctrl.sv
// text_area_ctrl: host-side controller for the 8x8 text area.
//
// Owns the single port of the 84x64 cell RAM. The video scan reader always
// wins the port. Host commands (single cell write, rectangle fill) use the
// cycles the reader leaves free. The block also holds the scroll-offset and
// alpha configuration registers that the text area datapath consumes.
//
// Optional feature macro: TEXT_AREA_CTRL_SHADOW_EN
//   defined   : scroll/alpha outputs reload from the shadow registers only on
//               i_frame_start, so the outputs change without tearing.
//   undefined : the shadow registers drive the outputs directly, and
//               i_frame_start is ignored.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_ready   host command channel (valid/ready)
//   i_frame_start         one-cycle pulse at the start of vertical blank
//   i_vid_req/i_vid_addr  video read request (has priority), o_vid_grant
//   o_ram_we/addr/wdata   cell RAM port (combinational mux)
//   o_scroll_x/y, o_alpha active configuration
//   o_busy                write or fill in progress
module text_area_ctrl #(
  parameter int unsigned CELL_COLS = 84,
  parameter int unsigned CELL_ROWS = 64,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_op,
  input  logic [6:0]        i_cmd_col,
  input  logic [5:0]        i_cmd_row,
  input  logic [6:0]        i_cmd_width,
  input  logic [5:0]        i_cmd_height,
  input  logic [15:0]       i_cmd_data,
  input  logic              i_frame_start,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_grant,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_wdata,
  output logic [4:0]        o_scroll_x,
  output logic [4:0]        o_scroll_y,
  output logic [2:0]        o_alpha,
  output logic              o_busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StFill  = 2'd2;

  localparam logic [2:0] OpWriteCell = 3'd1;
  localparam logic [2:0] OpFillRect  = 3'd2;
  localparam logic [2:0] OpSetScroll = 3'd3;
  localparam logic [2:0] OpSetAlpha  = 3'd4;

  localparam logic [7:0] ColsW = 8'(CELL_COLS);
  localparam logic [7:0] RowsW = 8'(CELL_ROWS);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_ok_q, wr_ok_d;
  // Fill counters are 8 bits so the end bounds (up to 84/64) never wrap.
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        row_start_q, row_start_d;
  logic [7:0]        col_end_q, col_end_d;
  logic [7:0]        row_end_q, row_end_d;
  logic [4:0]        sh_x_q, sh_x_d;
  logic [4:0]        sh_y_q, sh_y_d;
  logic [2:0]        sh_alpha_q, sh_alpha_d;

  logic              cmd_fire;
  logic [7:0]        cmd_col8, cmd_row8, width8, height8;
  logic [7:0]        col_room, row_room, eff_w, eff_h;
  logic              fill_empty;
  logic [ADDR_W-1:0] fsm_addr;

  assign cmd_fire = i_cmd_valid && (state_q == StIdle);
  assign cmd_col8 = {1'b0, i_cmd_col};
  assign cmd_row8 = {2'b00, i_cmd_row};
  assign width8   = {1'b0, i_cmd_width};
  assign height8  = {2'b00, i_cmd_height};

  // Clip the rectangle to the cell RAM; room values are only meaningful when
  // the start lies inside the area, which fill_empty guarantees.
  assign col_room   = ColsW - cmd_col8;
  assign row_room   = RowsW - cmd_row8;
  assign eff_w      = (width8 < col_room) ? width8 : col_room;
  assign eff_h      = (height8 < row_room) ? height8 : row_room;
  assign fill_empty = (i_cmd_width == 7'd0) || (i_cmd_height == 6'd0) ||
                      (cmd_col8 >= ColsW) || (cmd_row8 >= RowsW);

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_ok_d     = wr_ok_q;
    col_d       = col_q;
    row_d       = row_q;
    row_start_d = row_start_q;
    col_end_d   = col_end_q;
    row_end_d   = row_end_q;
    sh_x_d      = sh_x_q;
    sh_y_d      = sh_y_q;
    sh_alpha_d  = sh_alpha_q;

    case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          case (i_cmd_op)
            OpWriteCell: begin
              wr_addr_d = ADDR_W'({i_cmd_col, i_cmd_row});
              wr_data_d = i_cmd_data;
              wr_ok_d   = (cmd_col8 < ColsW) && (cmd_row8 < RowsW);
              state_d   = StWrite;
            end
            OpFillRect: begin
              wr_data_d   = i_cmd_data;
              col_d       = cmd_col8;
              row_d       = cmd_row8;
              row_start_d = cmd_row8;
              col_end_d   = cmd_col8 + eff_w;
              row_end_d   = cmd_row8 + eff_h;
              if (!fill_empty) state_d = StFill;
            end
            OpSetScroll: begin
              sh_x_d = i_cmd_data[4:0];
              sh_y_d = i_cmd_data[12:8];
            end
            OpSetAlpha: begin
              sh_alpha_d = i_cmd_data[2:0];
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        // An out-of-range target never writes, so it need not wait for a slot.
        if (!wr_ok_q || !i_vid_req) state_d = StIdle;
      end
      StFill: begin
        if (!i_vid_req) begin
          if (row_q + 8'd1 == row_end_q) begin
            row_d = row_start_q;
            if (col_q + 8'd1 == col_end_q) begin
              state_d = StIdle;
            end else begin
              col_d = col_q + 8'd1;
            end
          end else begin
            row_d = row_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ok_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      row_start_q <= '0;
      col_end_q   <= '0;
      row_end_q   <= '0;
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_alpha_q  <= 3'b011;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_ok_q     <= wr_ok_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_start_q <= row_start_d;
      col_end_q   <= col_end_d;
      row_end_q   <= row_end_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_alpha_q  <= sh_alpha_d;
    end
  end

`ifdef TEXT_AREA_CTRL_SHADOW_EN
  logic [4:0] act_x_q, act_y_q;
  logic [2:0] act_alpha_q;

  // A SET_* accepted on the frame_start cycle lands in the shadow only;
  // the active copy picks up the old shadow value here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_alpha_q <= 3'b011;
    end else if (i_frame_start) begin
      act_x_q     <= sh_x_q;
      act_y_q     <= sh_y_q;
      act_alpha_q <= sh_alpha_q;
    end
  end

  assign o_scroll_x = act_x_q;
  assign o_scroll_y = act_y_q;
  assign o_alpha    = act_alpha_q;
`else
  assign o_scroll_x = sh_x_q;
  assign o_scroll_y = sh_y_q;
  assign o_alpha    = sh_alpha_q;

  logic unused_frame;
  assign unused_frame = i_frame_start;
`endif

  // RAM port: video reads take priority and are never stalled.
  assign fsm_addr    = (state_q == StFill) ? ADDR_W'({col_q[6:0], row_q[5:0]}) : wr_addr_q;
  assign o_vid_grant = i_vid_req;
  assign o_ram_addr  = i_vid_req ? i_vid_addr : fsm_addr;
  assign o_ram_wdata = wr_data_q;
  assign o_ram_we    = !i_vid_req &&
                       (((state_q == StWrite) && wr_ok_q) || (state_q == StFill));

  assign o_cmd_ready = (state_q == StIdle);
  assign o_busy      = (state_q != StIdle);

  logic unused_cnt;
  assign unused_cnt = ^{col_q[7], row_q[7:6]};

endmodule

// File: tb/tb_text_area_ctrl.sv
module tb_text_area_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_op = '0;
  logic [6:0]  i_cmd_col = '0;
  logic [5:0]  i_cmd_row = '0;
  logic [6:0]  i_cmd_width = '0;
  logic [5:0]  i_cmd_height = '0;
  logic [15:0] i_cmd_data = '0;
  logic        i_frame_start = 1'b0;
  logic        i_vid_req = 1'b0;
  logic [12:0] i_vid_addr = '0;
  logic        o_vid_grant;
  logic        o_ram_we;
  logic [12:0] o_ram_addr;
  logic [15:0] o_ram_wdata;
  logic [4:0]  o_scroll_x;
  logic [4:0]  o_scroll_y;
  logic [2:0]  o_alpha;
  logic        o_busy;

  text_area_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_col    (i_cmd_col),
    .i_cmd_row    (i_cmd_row),
    .i_cmd_width  (i_cmd_width),
    .i_cmd_height (i_cmd_height),
    .i_cmd_data   (i_cmd_data),
    .i_frame_start(i_frame_start),
    .i_vid_req    (i_vid_req),
    .i_vid_addr   (i_vid_addr),
    .o_vid_grant  (o_vid_grant),
    .o_ram_we     (o_ram_we),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .o_scroll_x   (o_scroll_x),
    .o_scroll_y   (o_scroll_y),
    .o_alpha      (o_alpha),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;
  int wr_count = 0;
  logic [28:0] exp_q[$];  // {addr, data}

`ifdef TEXT_AREA_CTRL_SHADOW_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge i_clk) begin
    if (i_rst_n && o_ram_we) begin
      logic [28:0] e;
      wr_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL ram_write: unexpected write addr %0d data %h, required none",
                 o_ram_addr, o_ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({o_ram_addr, o_ram_wdata} !== e)
          $display("FAIL ram_write: addr %0d data %h, required addr %0d data %h",
                   o_ram_addr, o_ram_wdata, e[28:16], e[15:0]);
        else n_pass++;
      end
    end
  end

  task automatic push_rect(input int col, input int row, input int w, input int h,
                           input logic [15:0] data);
    for (int c = col; c < col + w; c++)
      for (int r = row; r < row + h; r++)
        if (c < 84 && r < 64) exp_q.push_back({13'(c * 64 + r), data});
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_cmd(input logic [2:0] op, input logic [6:0] col, input logic [5:0] row,
                          input logic [6:0] w, input logic [5:0] h, input logic [15:0] data,
                          input logic fs);
    int guard = 0;
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_col = col; i_cmd_row = row;
    i_cmd_width = w; i_cmd_height = h; i_cmd_data = data; i_frame_start = fs;
    while (!o_cmd_ready && guard < 500) begin
      @(posedge i_clk); #1; guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      $display("FAIL cmd_accept: ready stayed %b, required 1", o_cmd_ready);
    end
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0; i_frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (o_busy && guard < 500) begin
      @(posedge i_clk); #1; guard++;
    end
    n_checks++;
    if (o_busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL %s_done: busy %b pending %0d, required busy 0 pending 0",
               name, o_busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic pulse_frame();
    i_frame_start = 1'b1;
    @(posedge i_clk); #1;
    i_frame_start = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    n_checks++;
    if ({o_scroll_x, o_scroll_y, o_alpha, o_cmd_ready, o_busy, o_ram_we, o_ram_addr} !==
        {5'd0, 5'd0, 3'd3, 1'b1, 1'b0, 1'b0, 13'd0})
      $display("FAIL reset_in: x %0d y %0d a %0d rdy %b busy %b we %b addr %0d, required 0 0 3 1 0 0 0",
               o_scroll_x, o_scroll_y, o_alpha, o_cmd_ready, o_busy, o_ram_we, o_ram_addr);
    else n_pass++;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if ({o_scroll_x, o_scroll_y, o_alpha, o_cmd_ready, o_ram_we} !== {5'd0, 5'd0, 3'd3, 1'b1, 1'b0})
      $display("FAIL reset_out: x %0d y %0d a %0d rdy %b we %b, required 0 0 3 1 0",
               o_scroll_x, o_scroll_y, o_alpha, o_cmd_ready, o_ram_we);
    else n_pass++;
  endtask

  task automatic test_write_cell();
    exp_q.push_back({13'd322, 16'hF141});
    send_cmd(3'd1, 7'd5, 6'd2, 7'd0, 6'd0, 16'hF141, 1'b0);
    n_checks++;
    if ({o_cmd_ready, o_busy} !== 2'b01)
      $display("FAIL write_busy: rdy %b busy %b, required 0 1", o_cmd_ready, o_busy);
    else n_pass++;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_cmd_ready !== 1'b1)
      $display("FAIL write_ready_n2: rdy %b, required 1", o_cmd_ready);
    else n_pass++;
    wait_idle("write_cell");
    // Out-of-range column: WRITE is entered for one cycle, nothing written.
    send_cmd(3'd1, 7'd90, 6'd2, 7'd0, 6'd0, 16'h1111, 1'b0);
    n_checks++;
    if (o_busy !== 1'b1) $display("FAIL write_oor_busy: busy %b, required 1", o_busy);
    else n_pass++;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_cmd_ready !== 1'b1) $display("FAIL write_oor_ready: rdy %b, required 1", o_cmd_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({13'd0, 16'hAAAA});
    exp_q.push_back({13'(83 * 64 + 63), 16'h5555});
    send_cmd(3'd1, 7'd0, 6'd0, 7'd0, 6'd0, 16'hAAAA, 1'b0);
    send_cmd(3'd1, 7'd83, 6'd63, 7'd0, 6'd0, 16'h5555, 1'b0);
    wait_idle("back_to_back");
  endtask

  task automatic test_fill_clip();
    int base = wr_count;
    push_rect(82, 62, 4, 4, 16'h0720);
    send_cmd(3'd2, 7'd82, 6'd62, 7'd4, 6'd4, 16'h0720, 1'b0);
    wait_idle("fill_clip");
    n_checks++;
    if (wr_count - base !== 4) $display("FAIL fill_clip_count: %0d writes, required 4", wr_count - base);
    else n_pass++;
    // Empty extents never leave IDLE.
    send_cmd(3'd2, 7'd3, 6'd3, 7'd0, 6'd5, 16'h0001, 1'b0);
    n_checks++;
    if (o_cmd_ready !== 1'b1) $display("FAIL fill_w0_ready: rdy %b, required 1", o_cmd_ready);
    else n_pass++;
    send_cmd(3'd2, 7'd100, 6'd3, 7'd5, 6'd5, 16'h0002, 1'b0);
    n_checks++;
    if (o_cmd_ready !== 1'b1) $display("FAIL fill_oor_ready: rdy %b, required 1", o_cmd_ready);
    else n_pass++;
  endtask

  task automatic test_vid_stall();
    int base = wr_count;
    push_rect(10, 20, 2, 2, 16'h1234);
    send_cmd(3'd2, 7'd10, 6'd20, 7'd2, 6'd2, 16'h1234, 1'b0);
    @(posedge i_clk); #1;
    i_vid_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_vid_addr = 13'(8000 + i * 7);
      #1;
      n_checks++;
      if ({o_ram_addr, o_ram_we, o_vid_grant, o_busy} !== {13'(8000 + i * 7), 1'b0, 1'b1, 1'b1})
        $display("FAIL vid_pass_%0d: addr %0d we %b grant %b busy %b, required %0d 0 1 1",
                 i, o_ram_addr, o_ram_we, o_vid_grant, o_busy, 8000 + i * 7);
      else n_pass++;
      @(posedge i_clk); #1;
    end
    i_vid_req = 1'b0;
    wait_idle("vid_stall");
    n_checks++;
    if (wr_count - base !== 4) $display("FAIL vid_stall_count: %0d writes, required 4", wr_count - base);
    else n_pass++;
  endtask

  task automatic test_config();
    send_cmd(3'd3, 7'd0, 6'd0, 7'd0, 6'd0, 16'h0A07, 1'b0);
    n_checks++;
    if ({o_scroll_x, o_scroll_y} !== (ShadowEn ? {5'd0, 5'd0} : {5'd7, 5'd10}))
      $display("FAIL scroll_accept: x %0d y %0d, required %0d %0d",
               o_scroll_x, o_scroll_y, ShadowEn ? 0 : 7, ShadowEn ? 0 : 10);
    else n_pass++;
    pulse_frame();
    n_checks++;
    if ({o_scroll_x, o_scroll_y} !== {5'd7, 5'd10})
      $display("FAIL scroll_frame: x %0d y %0d, required 7 10", o_scroll_x, o_scroll_y);
    else n_pass++;
    // SET_ALPHA coinciding with frame_start: active keeps the old shadow.
    send_cmd(3'd4, 7'd0, 6'd0, 7'd0, 6'd0, 16'h0005, 1'b1);
    n_checks++;
    if (o_alpha !== (ShadowEn ? 3'd3 : 3'd5))
      $display("FAIL alpha_same_frame: alpha %0d, required %0d", o_alpha, ShadowEn ? 3 : 5);
    else n_pass++;
    pulse_frame();
    n_checks++;
    if (o_alpha !== 3'd5) $display("FAIL alpha_frame: alpha %0d, required 5", o_alpha);
    else n_pass++;
    // NOP and ignored opcodes change nothing and write nothing.
    send_cmd(3'd6, 7'd1, 6'd1, 7'd3, 6'd3, 16'hFFFF, 1'b0);
    send_cmd(3'd0, 7'd1, 6'd1, 7'd3, 6'd3, 16'hFFFF, 1'b0);
    pulse_frame();
    n_checks++;
    if ({o_cmd_ready, o_scroll_x, o_scroll_y, o_alpha} !== {1'b1, 5'd7, 5'd10, 3'd5})
      $display("FAIL ignored_ops: rdy %b x %0d y %0d a %0d, required 1 7 10 5",
               o_cmd_ready, o_scroll_x, o_scroll_y, o_alpha);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    int base = wr_count;
    int guard = 0;
    push_rect(0, 0, 10, 10, 16'hBEEF);
    send_cmd(3'd2, 7'd0, 6'd0, 7'd10, 6'd10, 16'hBEEF, 1'b0);
    while (wr_count - base < 20 && guard < 200) begin
      @(posedge i_clk); #1; guard++;
    end
    i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if ({o_ram_we, o_busy, o_cmd_ready, o_alpha, o_scroll_x, o_scroll_y} !==
        {1'b0, 1'b0, 1'b1, 3'd3, 5'd0, 5'd0} || wr_count - base !== 20)
      $display("FAIL reset_abort: we %b busy %b rdy %b a %0d x %0d y %0d writes %0d, required 0 0 1 3 0 0 20",
               o_ram_we, o_busy, o_cmd_ready, o_alpha, o_scroll_x, o_scroll_y, wr_count - base);
    else n_pass++;
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    n_checks++;
    if (wr_count - base !== 20 || o_busy !== 1'b0)
      $display("FAIL reset_quiet: writes %0d busy %b, required 20 0", wr_count - base, o_busy);
    else n_pass++;
    exp_q.push_back({13'd65, 16'h0C33});
    send_cmd(3'd1, 7'd1, 6'd1, 7'd0, 6'd0, 16'h0C33, 1'b0);
    wait_idle("after_reset");
  endtask

  initial begin
    test_reset();
    test_write_cell();
    test_back_to_back();
    test_fill_clip();
    test_vid_stall();
    test_config();
    test_reset_mid_fill();
    repeat (3) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
